// File: rtl/memory_pkg.sv
// Shared types and address-decode constants for the memory responder.
package Memory_Pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'hFFFF_0000;
  localparam logic [1:0]  ALIGN_MASK        = 2'b11;
  localparam int          WORD_SHIFT        = 2;

  // True when the byte address is word aligned and lands inside the array.
  function automatic logic is_ram_addr(
    input logic [31:0] a,
    input int          aw
  );
    logic [31:0] hi;
    hi = a >> (aw + WORD_SHIFT);
    return ((a[1:0] & ALIGN_MASK) == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port word array with synchronous write and synchronous read.
module Single_Port_RAM #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Req/ready memory target: word RAM, one GPIO byte register, error replies.
// Optional wait states: define MEMORY_RESPONDER_WAIT_STATES_EN.
module memory_responder
  import Memory_Pkg::*;
#(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] GPIO_ADDR   = GPIO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Req,
  input  logic        Mem_Write,
  input  logic [31:0] Addr,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Mem_Ready,
  output logic        Mem_Err,
  output logic [7:0]  GPIO_Out
);

  state_t      state;
  state_t      state_nxt;
  logic        go_resp;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  gpio_q;

  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_ram;
  logic        cur_gpio;

  logic        resp_ram;
  logic        resp_gpio;
  logic [31:0] ram_q;

`ifdef MEMORY_RESPONDER_WAIT_STATES_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
`endif

  // In IDLE the commit edge may be the accepting edge, so use live inputs.
  assign cur_write = (state == IDLE) ? Mem_Write  : write_q;
  assign cur_addr  = (state == IDLE) ? Addr       : addr_q;
  assign cur_wdata = (state == IDLE) ? Write_Data : wdata_q;
  assign cur_ram   = is_ram_addr(cur_addr, ADDR_WIDTH);
  assign cur_gpio  = (cur_addr == GPIO_ADDR);

  always_comb begin
    state_nxt = state;
    go_resp   = 1'b0;
`ifdef MEMORY_RESPONDER_WAIT_STATES_EN
    cnt_nxt   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (Mem_Req) begin
`ifdef MEMORY_RESPONDER_WAIT_STATES_EN
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = RESP;
            go_resp   = 1'b1;
          end
`else
          state_nxt = RESP;
          go_resp   = 1'b1;
`endif
        end
      end
`ifdef MEMORY_RESPONDER_WAIT_STATES_EN
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end else begin
          cnt_nxt = CW'(cnt - 1'b1);
        end
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
`ifdef MEMORY_RESPONDER_WAIT_STATES_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef MEMORY_RESPONDER_WAIT_STATES_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && Mem_Req) begin
      write_q <= Mem_Write;
      addr_q  <= Addr;
      wdata_q <= Write_Data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_q <= 8'h00;
    end else if (go_resp && cur_gpio && cur_write) begin
      gpio_q <= cur_wdata[7:0];
    end
  end

  Single_Port_RAM #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (go_resp && cur_ram),
    .we    (cur_write),
    .addr  (cur_addr[ADDR_WIDTH+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  assign resp_ram  = is_ram_addr(addr_q, ADDR_WIDTH);
  assign resp_gpio = (addr_q == GPIO_ADDR);

  assign Mem_Ready = (state == RESP);
  assign Mem_Err   = Mem_Ready && !resp_ram && !resp_gpio;
  assign GPIO_Out  = gpio_q;

  always_comb begin
    Read_Data = '0;
    if (Mem_Ready && !write_q) begin
      unique case (1'b1)
        resp_gpio: Read_Data = {24'b0, gpio_q};
        resp_ram:  Read_Data = ram_q;
        default:   Read_Data = '0;
      endcase
    end
  end

endmodule
